ensemble_vote_combiner: RTL and testbench



---
 rtl/ensemble_pkg.sv | 24 ++
 rtl/vote_tally.sv | 130 +++++++++++++
 rtl/ensemble_vote_combiner.sv | 151 +++++++++++++++
 tb/tb_ensemble_vote_combiner.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ensemble_pkg.sv
// Shared types and result-word layout for the ensemble vote combiner.
// The helper sizes the per-class vote counters so they can never overflow.
package ensemble_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        TALLY,
        SELECT,
        OUTPUT
    } state_t;

    localparam int CLS_LSB    = 0;
    localparam int CNT_LSB    = 8;
    localparam int NCH_LSB    = 16;
    localparam int NOVOTE_BIT = 30;
    localparam int UNAN_BIT   = 31;

    // Width that holds 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vote_tally.sv
// Per-class vote counters: sequential tally over the channels, then an argmax scan.
// Started by a one-cycle pulse; tally_done/done mark the last cycle of each phase.
module vote_tally
    import ensemble_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int CLASS_WIDTH = 4,
    parameter int NUM_CLASSES = 10,
    localparam int CW         = cnt_width(NUM_CH)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                clear,
    input  logic [NUM_CH-1:0]                   en,
    input  logic [NUM_CH-1:0][CLASS_WIDTH-1:0]  lbl,
    output logic                                tally_done,
    output logic                                done,
    output logic                                bad_hit,
    output logic [CLASS_WIDTH-1:0]              best_cls,
    output logic [CW-1:0]                       best_cnt
);

    localparam int IW = $clog2(((NUM_CH > NUM_CLASSES) ? NUM_CH : NUM_CLASSES) + 1);
    localparam logic [CLASS_WIDTH:0] NCLS = (CLASS_WIDTH + 1)'(NUM_CLASSES);

    state_t                             phase_q, phase_d;
    logic [IW-1:0]                      idx_q, idx_d;
    logic [NUM_CLASSES-1:0][CW-1:0]     cnt_q, cnt_d;
    logic [CLASS_WIDTH-1:0]             best_cls_q, best_cls_d;
    logic [CW-1:0]                      best_cnt_q, best_cnt_d;

    logic                               cur_en;
    logic [CLASS_WIDTH-1:0]             cur_lbl;
    logic [CW-1:0]                      cur_cnt;
    logic [CLASS_WIDTH-1:0]             cur_cls;

    always_comb begin
        phase_d    = phase_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        best_cls_d = best_cls_q;
        best_cnt_d = best_cnt_q;
        tally_done = 1'b0;
        done       = 1'b0;
        bad_hit    = 1'b0;
        cur_en     = 1'b0;
        cur_lbl    = '0;
        cur_cnt    = '0;
        cur_cls    = '0;

        // idx walks channels during TALLY and classes during SELECT
        for (int j = 0; j < NUM_CH; j++) begin
            if (idx_q == IW'(j)) begin
                cur_en  = en[j];
                cur_lbl = lbl[j];
            end
        end
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (idx_q == IW'(k)) begin
                cur_cnt = cnt_q[k];
                cur_cls = CLASS_WIDTH'(k);
            end
        end

        case (phase_q)
            IDLE: begin
                if (clear) cnt_d = '0;
                if (start) begin
                    phase_d = TALLY;
                    idx_d   = '0;
                end
            end
            TALLY: begin
                if (cur_en) begin
                    if ({1'b0, cur_lbl} < NCLS) begin
                        for (int k = 0; k < NUM_CLASSES; k++) begin
                            if (cur_lbl == CLASS_WIDTH'(k)) cnt_d[k] = cnt_q[k] + 1'b1;
                        end
                    end else begin
                        bad_hit = 1'b1;
                    end
                end
                if (idx_q == IW'(NUM_CH - 1)) begin
                    phase_d    = SELECT;
                    idx_d      = '0;
                    best_cls_d = '0;
                    best_cnt_d = '0;
                    tally_done = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            SELECT: begin
                // strict compare keeps the lowest class on ties
                if (cur_cnt > best_cnt_q) begin
                    best_cnt_d = cur_cnt;
                    best_cls_d = cur_cls;
                end
                if (idx_q == IW'(NUM_CLASSES - 1)) begin
                    phase_d = IDLE;
                    done    = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: phase_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            best_cls_q <= '0;
            best_cnt_q <= '0;
        end else begin
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            best_cls_q <= best_cls_d;
            best_cnt_q <= best_cnt_d;
        end
    end

    assign best_cls = best_cls_q;
    assign best_cnt = best_cnt_q;

endmodule

// File: rtl/ensemble_vote_combiner.sv
// N-way majority voter: captures one label per enabled AXI-Stream channel,
// tallies them in vote_tally and emits a single-beat result word.
module ensemble_vote_combiner
    import ensemble_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_WIDTH  = 4,
    parameter int CLASS_WIDTH = 4,
    parameter int NUM_CLASSES = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              ch_enable,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_CH*KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic [NUM_CH-1:0]              s_axis_tvalid,
    output logic [NUM_CH-1:0]              s_axis_tready,
    input  logic [NUM_CH-1:0]              s_axis_tlast,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [15:0]                    bad_label_cnt
);

    localparam int CW = cnt_width(NUM_CH);

    state_t                              state_q, state_d;
    logic [NUM_CH-1:0]                   en_r_q, en_r_d;
    logic [NUM_CH-1:0]                   captured_q, captured_d;
    logic [NUM_CH-1:0][CLASS_WIDTH-1:0]  lbl_q, lbl_d;
    logic [15:0]                         bad_cnt_q, bad_cnt_d;

    logic [NUM_CH-1:0]                   hs;
    logic                                tally_start, tally_clear;
    logic                                tally_done, sel_done, bad_hit;
    logic [CLASS_WIDTH-1:0]              best_cls;
    logic [CW-1:0]                       best_cnt;
    logic [CW-1:0]                       nch;

    // tkeep/tlast carry no information here; only the label bits of tdata are used
    logic unused_inputs;
    assign unused_inputs = ^{s_axis_tkeep, s_axis_tlast, s_axis_tdata};

    always_comb begin
        s_axis_tready = '0;
        if (state_q == COLLECT) s_axis_tready = en_r_q & ~captured_q;
    end

    assign hs = s_axis_tvalid & s_axis_tready;

    always_comb begin
        state_d     = state_q;
        en_r_d      = en_r_q;
        captured_d  = captured_q;
        lbl_d       = lbl_q;
        tally_start = 1'b0;
        tally_clear = 1'b0;
        bad_cnt_d   = bad_cnt_q;
        if (bad_hit && (bad_cnt_q != 16'hFFFF)) bad_cnt_d = bad_cnt_q + 16'd1;

        case (state_q)
            IDLE: begin
                en_r_d     = ch_enable;
                captured_d = '0;
                if (ch_enable != '0) state_d = COLLECT;
            end
            COLLECT: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (hs[i]) lbl_d[i] = s_axis_tdata[i*DATA_WIDTH +: CLASS_WIDTH];
                end
                captured_d = captured_q | hs;
                if ((captured_q | hs) == en_r_q) begin
                    state_d     = TALLY;
                    tally_start = 1'b1;
                end
            end
            TALLY:  if (tally_done) state_d = SELECT;
            SELECT: if (sel_done) state_d = OUTPUT;
            OUTPUT: begin
                if (m_axis_tready) begin
                    state_d     = IDLE;
                    tally_clear = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            en_r_q     <= '0;
            captured_q <= '0;
            lbl_q      <= '0;
            bad_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            en_r_q     <= en_r_d;
            captured_q <= captured_d;
            lbl_q      <= lbl_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    vote_tally #(
        .NUM_CH      (NUM_CH),
        .CLASS_WIDTH (CLASS_WIDTH),
        .NUM_CLASSES (NUM_CLASSES)
    ) u_tally (
        .clk        (clk),
        .rst        (rst),
        .start      (tally_start),
        .clear      (tally_clear),
        .en         (en_r_q),
        .lbl        (lbl_q),
        .tally_done (tally_done),
        .done       (sel_done),
        .bad_hit    (bad_hit),
        .best_cls   (best_cls),
        .best_cnt   (best_cnt)
    );

    always_comb begin
        nch = '0;
        for (int i = 0; i < NUM_CH; i++) nch = nch + CW'(en_r_q[i]);
    end

    // Result word is built from held registers, so it stays stable under backpressure
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        if (state_q == OUTPUT) begin
            m_axis_tvalid                          = 1'b1;
            m_axis_tlast                           = 1'b1;
            m_axis_tkeep                           = '1;
            m_axis_tdata[CLS_LSB +: CLASS_WIDTH]   = best_cls;
            m_axis_tdata[CNT_LSB +: 8]             = 8'(best_cnt);
            m_axis_tdata[NCH_LSB +: 8]             = 8'(nch);
            m_axis_tdata[NOVOTE_BIT]               = (best_cnt == '0);
            m_axis_tdata[UNAN_BIT]                 = (best_cnt == nch);
        end
    end

    assign bad_label_cnt = bad_cnt_q;

endmodule

// File: tb/tb_ensemble_vote_combiner.sv
// Scoreboard bench for ensemble_vote_combiner: directed rounds plus random rounds,
// expected words from a counting reference model, checked by an independent monitor.
module tb_ensemble_vote_combiner;

    localparam int NCH  = 3;
    localparam int DW   = 32;
    localparam int KW   = 4;
    localparam int CLW  = 4;
    localparam int NCLS = 10;
    localparam int LAT  = NCH + NCLS + 1;

    logic              clk;
    logic              rst;
    logic [NCH-1:0]    ch_enable;
    logic [NCH*DW-1:0] s_axis_tdata;
    logic [NCH*KW-1:0] s_axis_tkeep;
    logic [NCH-1:0]    s_axis_tvalid;
    logic [NCH-1:0]    s_axis_tready;
    logic [NCH-1:0]    s_axis_tlast;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic [15:0]       bad_label_cnt;

    ensemble_vote_combiner #(
        .NUM_CH(NCH), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
        .CLASS_WIDTH(CLW), .NUM_CLASSES(NCLS)
    ) dut (
        .clk(clk), .rst(rst), .ch_enable(ch_enable),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .bad_label_cnt(bad_label_cnt)
    );

    typedef struct {
        logic [31:0] word;
        int          bad;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          bad_model = 0;
    int          stall_left = 0;
    int          last_cap = 0;
    bit          lat_armed = 0;
    bit          stalled = 0;
    bit          prev_v = 0;
    logic [31:0] held;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: count valid votes per class, pick the most-voted (lowest class on ties)
    function automatic logic [31:0] model(input logic [NCH-1:0] en, input int lbl[NCH],
                                          output int nb);
        int cnt[NCLS];
        int nch, best, bc;
        logic [31:0] w;
        nb = 0; nch = 0; best = 0; bc = 0;
        for (int c = 0; c < NCLS; c++) cnt[c] = 0;
        for (int i = 0; i < NCH; i++) begin
            if (en[i]) begin
                nch++;
                if (lbl[i] < NCLS) cnt[lbl[i]]++;
                else nb++;
            end
        end
        for (int c = 0; c < NCLS; c++) begin
            if (cnt[c] > bc) begin
                bc = cnt[c];
                best = c;
            end
        end
        w = 32'(best) | (32'(bc) << 8) | (32'(nch) << 16);
        if (bc == 0) w[30] = 1'b1;
        if (bc == nch) w[31] = 1'b1;
        return w;
    endfunction

    // Downstream ready: hold low for stall_left cycles once a result appears
    always @(posedge clk) begin
        #1;
        if (m_axis_tvalid && stall_left > 0) begin
            m_axis_tready = 1'b0;
            stall_left--;
        end else begin
            m_axis_tready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every output handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_tvalid && !prev_v && lat_armed) begin
                chk("latency", 64'(cyc - last_cap), 64'(LAT));
                lat_armed = 0;
            end
            if (stalled && m_axis_tvalid) chk("stall_stable", m_axis_tdata, held);
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected no beat", m_axis_tdata);
                end else begin
                    e = sb.pop_front();
                    chk("tdata", m_axis_tdata, e.word);
                    chk("tlast", m_axis_tlast, 1);
                    chk("tkeep", m_axis_tkeep, 4'hF);
                    chk("bad_label_cnt", bad_label_cnt, 64'(e.bad));
                end
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            held    = m_axis_tdata;
            prev_v  = m_axis_tvalid;
        end else begin
            stalled = 0;
            prev_v  = 0;
        end
    end

    task automatic run_round(input logic [NCH-1:0] en, input int l0, input int l1, input int l2,
                             input int d0, input int d1, input int d2,
                             input bit hold_dis, input int stall, input bit abort);
        int lbl[NCH];
        int d[NCH];
        int got[NCH];
        int nb;
        bit all;
        bit dis_rdy;
        logic [31:0] w;
        lbl = '{l0, l1, l2};
        d   = '{d0, d1, d2};
        got = '{0, 0, 0};
        dis_rdy = 0;
        all = 0;
        if (!abort) begin
            w = model(en, lbl, nb);
            bad_model += nb;
            sb.push_back('{w, bad_model});
        end
        stall_left = stall;
        for (int i = 0; i < NCH; i++) begin
            s_axis_tdata[i*DW +: DW]  = $urandom();
            s_axis_tdata[i*DW +: CLW] = CLW'(lbl[i]);
        end
        s_axis_tkeep = NCH*KW'($urandom());
        s_axis_tlast = NCH'($urandom());
        ch_enable = en;
        for (int c = 0; c < 80 && !all; c++) begin
            for (int i = 0; i < NCH; i++) begin
                s_axis_tvalid[i] = en[i] ? (c >= d[i]) : hold_dis;
                // a repeat capture would pull in this bad label and change the result
                if (got[i] > 0) s_axis_tdata[i*DW +: CLW] = 4'hF;
            end
            @(negedge clk);
            for (int i = 0; i < NCH; i++) begin
                if (s_axis_tvalid[i] && s_axis_tready[i]) begin
                    got[i]++;
                    last_cap = cyc;
                end
                if (!en[i] && s_axis_tready[i]) dis_rdy = 1;
            end
            @(posedge clk); #1;
            if (c == 0) ch_enable = '0;
            all = 1;
            for (int i = 0; i < NCH; i++) if (en[i] && got[i] == 0) all = 0;
        end
        if (!all) begin
            checks++;
            errors++;
            $display("FAIL collect_timeout: captured %0d/%0d/%0d required all enabled", got[0], got[1], got[2]);
        end
        if (abort) begin
            s_axis_tvalid = '0;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            bad_model = 0;
            @(negedge clk);
            chk("abort_tvalid", m_axis_tvalid, 0);
            chk("abort_tready", s_axis_tready, 0);
            chk("abort_bad_cnt", bad_label_cnt, 0);
            chk("abort_tdata", m_axis_tdata, 0);
            @(posedge clk); #1;
            return;
        end
        lat_armed = 1;
        for (int h = 0; h < 3; h++) begin
            for (int i = 0; i < NCH; i++) if (got[i] > 0) s_axis_tdata[i*DW +: CLW] = 4'hF;
            @(negedge clk);
            for (int i = 0; i < NCH; i++) begin
                if (s_axis_tvalid[i] && s_axis_tready[i]) got[i]++;
                if (!en[i] && s_axis_tready[i]) dis_rdy = 1;
            end
            @(posedge clk); #1;
        end
        s_axis_tvalid = '0;
        for (int i = 0; i < NCH; i++) chk($sformatf("captures_ch%0d", i), 64'(got[i]), en[i] ? 1 : 0);
        chk("disabled_ready", 64'(dis_rdy), 0);
        for (int t = 0; t < 200 && sb.size() != 0; t++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL output_timeout: got no result beat expected %h", sb[0].word);
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ch_enable = '0;
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tvalid = '0;
        s_axis_tlast = '0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tvalid", m_axis_tvalid, 0);
        chk("reset_tready", s_axis_tready, 0);
        chk("reset_tdata", m_axis_tdata, 0);
        chk("reset_bad_cnt", bad_label_cnt, 0);
        @(posedge clk); #1;

        run_round(3'b111, 2, 2, 5, 0, 0, 0, 0, 0, 0);
        run_round(3'b111, 7, 3, 1, 0, 1, 2, 0, 1, 0);
        run_round(3'b111, 4, 4, 4, 1, 0, 0, 0, 0, 0);
        run_round(3'b101, 6, 9, 6, 0, 0, 1, 1, 0, 0);
        run_round(3'b111, 12, 15, 3, 0, 0, 0, 0, 0, 0);
        run_round(3'b111, 12, 13, 14, 0, 0, 0, 0, 2, 0);
        run_round(3'b111, 1, 4, 1, 5, 7, 0, 0, 4, 0);
        run_round(3'b111, 12, 1, 13, 0, 0, 0, 0, 0, 1);
        run_round(3'b111, 1, 1, 0, 0, 0, 0, 0, 0, 0);

        for (int r = 0; r < 40; r++) begin
            run_round(NCH'($urandom_range(1, 7)),
                      $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12),
                      $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
        end

        chk("scoreboard_empty", 64'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
